// File: rtl/hdr_classifier.sv
// hdr_classifier: parses Ethernet/IPv4/L4 headers from an AXI-stream packet and emits a rule-matched descriptor through a FIFO
// Ports: clk/rst_n (async active-low); s_axis_* packet input (byte 0 at [7:0]);
// cfg_we/cfg_addr/cfg_wdata rule write {en,is_tcp,rr,port_src,chain,prio,flow_id,time};
// m_desc_* descriptor output with valid/ready; stat_* packet/udp/match counters.
// Build option: define HDR_CLASSIFIER_STATS_EN to build the stat_* counters, otherwise they read 0.
module hdr_classifier #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int RULE_COUNT = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int AW = (RULE_COUNT > 1) ? $clog2(RULE_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [66:0]           cfg_wdata,
  output logic                  m_desc_valid,
  input  logic                  m_desc_ready,
  output logic [7:0]            m_desc_prio,
  output logic [15:0]           m_desc_chain,
  output logic [15:0]           m_desc_time,
  output logic [15:0]           m_desc_pk_len,
  output logic [7:0]            m_desc_flow_id,
  output logic [2:0]            m_desc_flags,
  output logic [31:0]           stat_pkt_count,
  output logic [31:0]           stat_udp_count,
  output logic [31:0]           stat_match_count
);
  localparam int HB = 38;
  localparam int HDR_BEATS = (HB + KEEP_WIDTH - 1) / KEEP_WIDTH;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, HDR, BODY, EMIT} state_t;
  state_t r_state, w_next;
  logic [2:0] r_beat, w_bidx;
  logic [15:0] r_len, w_base, w_keep_cnt, w_port, w_pk_len;
  logic [7:0] r_hdr [HB];
  logic [66:0] r_rule [RULE_COUNT];
  logic [RULE_COUNT-1:0] r_tog;
  logic [66:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0] r_cnt;
  logic [AW-1:0] w_idx;
  logic [66:0] w_rule, w_desc;
  logic [3:0] w_item1;
  logic w_acc, w_sop, w_push, w_deq, w_runt, w_ipv4, w_l4ok, w_udp, w_tcp, w_hit;
  assign w_acc = s_axis_tvalid && s_axis_tready;
  // EMIT lasts one cycle, so a beat arriving then already belongs to the next packet
  assign w_sop = (r_state == IDLE) || (r_state == EMIT);
  assign w_bidx = w_sop ? 3'd0 : r_beat;
  assign w_base = w_sop ? 16'd0 : r_len;
  assign w_push = (r_state == EMIT);
  assign w_deq = m_desc_valid && m_desc_ready;
  assign m_desc_valid = (r_cnt != '0);
  // A new packet may only start if its eventual push still fits behind any push in flight
  assign s_axis_tready = !(((r_state == IDLE) && (r_cnt == (PW+1)'(FIFO_DEPTH))) ||
                           ((r_state == EMIT) && (r_cnt >= (PW+1)'(FIFO_DEPTH - 1))));
  always_comb begin
    w_keep_cnt = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) w_keep_cnt = w_keep_cnt + 16'(s_axis_tkeep[k]);
  end
  always_comb begin
    w_next = (r_state == EMIT) ? IDLE : r_state;
    if (w_acc) w_next = s_axis_tlast ? EMIT : (((int'(w_bidx) + 1) * KEEP_WIDTH >= HB) ? BODY : HDR);
  end
  // Classification runs in EMIT on the fully captured header and final byte count
  assign w_runt = r_len < 16'd38;
  assign w_ipv4 = !w_runt && ({r_hdr[12], r_hdr[13]} == 16'h0800);
  assign w_l4ok = w_ipv4 && (r_hdr[14][3:0] == 4'd5);
  assign w_udp = w_l4ok && (r_hdr[23] == 8'h11);
  assign w_tcp = w_l4ok && (r_hdr[23] == 8'h06);
  assign w_port = {r_hdr[34], r_hdr[35]};
  assign w_pk_len = w_ipv4 ? {r_hdr[16], r_hdr[17]} + 16'd14 : r_len;
  // Scan downwards so the lowest matching index is the last to win
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int r = RULE_COUNT - 1; r >= 0; r--)
      if (r_rule[r][66] && (r_rule[r][65] == w_tcp) && (r_rule[r][63:48] == w_port) && (w_udp || w_tcp)) begin
        w_hit = 1'b1;
        w_idx = AW'(r);
      end
  end
  assign w_rule = r_rule[w_idx];
  assign w_item1 = w_rule[39:36] + {3'b0, w_rule[64] & r_tog[w_idx]};
  assign w_desc = w_hit ? {w_rule[31:24], w_rule[47:40], w_item1, w_rule[35:32], w_rule[15:0], w_pk_len, w_rule[23:16], w_runt, w_tcp, w_udp}
                        : {8'd1, 16'd0, 16'd2, w_pk_len, 8'hFF, w_runt, w_tcp, w_udp};
  assign {m_desc_prio, m_desc_chain, m_desc_time, m_desc_pk_len, m_desc_flow_id, m_desc_flags} = m_desc_valid ? r_mem[r_rp] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_beat <= '0;
      r_len <= '0;
      r_tog <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      for (int i = 0; i < HB; i++) r_hdr[i] <= '0;
      for (int r = 0; r < RULE_COUNT; r++) r_rule[r] <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_beat <= (w_bidx == 3'(HDR_BEATS)) ? w_bidx : w_bidx + 3'd1;
        r_len <= w_base + (s_axis_tlast ? w_keep_cnt : 16'(KEEP_WIDTH));
        for (int i = 0; i < HB; i++)
          if (w_bidx == 3'(i / KEEP_WIDTH)) r_hdr[i] <= s_axis_tdata[(i % KEEP_WIDTH) * 8 +: 8];
      end
      if (cfg_we && (int'(cfg_addr) < RULE_COUNT)) r_rule[cfg_addr] <= cfg_wdata;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_push && w_hit) r_tog[w_idx] <= ~r_tog[w_idx];
      if (w_deq) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_deq);
    end
  end
  always_ff @(posedge clk) if (w_push) r_mem[r_wp] <= w_desc;
`ifdef HDR_CLASSIFIER_STATS_EN
  logic [31:0] r_pkt, r_udp, r_match;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt <= '0;
      r_udp <= '0;
      r_match <= '0;
    end else if (w_push) begin
      r_pkt <= r_pkt + 32'd1;
      r_udp <= r_udp + 32'(w_udp);
      r_match <= r_match + 32'(w_hit);
    end
  end
  assign stat_pkt_count = r_pkt;
  assign stat_udp_count = r_udp;
  assign stat_match_count = r_match;
`else
  assign stat_pkt_count = '0;
  assign stat_udp_count = '0;
  assign stat_match_count = '0;
`endif
endmodule

// File: doc/hdr_classifier.md
HDR_CLASSIFIER -- requirements
Module: hdr_classifier

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, AXI-stream data width in bits; legal values 64..512, power of two.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, tkeep width.
REQ-003 SHALL have parameter RULE_COUNT, default 4, number of port-match rules; legal values 1..16.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, descriptor FIFO entries; power of two, at least 2.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-007 SHALL have s_axis_tdata in DATA_WIDTH, s_axis_tkeep in KEEP_WIDTH, s_axis_tvalid in 1, s_axis_tlast in 1: packet input, byte 0 at bits [7:0].
REQ-008 SHALL have port s_axis_tready, output, 1, input beat accepted when tvalid and tready are both high.
REQ-009 SHALL have cfg_we in 1, cfg_addr in clog2(RULE_COUNT) (min 1), cfg_wdata in 67: rule write port.
REQ-010 SHALL have m_desc_valid out 1 and m_desc_ready in 1: descriptor handshake.
REQ-011 SHALL have the descriptor outputs m_desc_prio 8, m_desc_chain 16 (four 4-bit items, item0 at [3:0]), m_desc_time 16, m_desc_pk_len 16, m_desc_flow_id 8, m_desc_flags 3 ({runt, tcp, udp}).
REQ-012 SHALL have outputs stat_pkt_count, stat_udp_count and stat_match_count, each 32 bits.

Function
REQ-013 cfg_wdata layout SHALL be, MSB to LSB: en[66], is_tcp[65], rr[64], port_src[63:48], chain[47:32], prio[31:24], flow_id[23:16], time[15:0]; the write takes effect at the clock edge with cfg_we high.
REQ-014 The FSM SHALL have the states IDLE, HDR, BODY, EMIT.
REQ-015 FSM transitions SHALL be: IDLE->HDR on the first accepted beat; HDR->BODY once bytes 0..37 are captured; any state->EMIT on the accepted tlast beat; EMIT->IDLE after one cycle.
REQ-016 A beat counter SHALL capture header bytes 0..37 across ceil(38/KEEP_WIDTH) beats; each byte SHALL be taken from beat floor(i/KEEP_WIDTH), lane i%KEEP_WIDTH.
REQ-017 Field decoding: ethertype = bytes 12..13, ipv4 when 0x0800; IHL = byte 14 [3:0]; ip_len = bytes 16..17; proto = byte 23; port_src = bytes 34..35; all fields big-endian.
REQ-018 udp SHALL be set when ipv4 && IHL==5 && proto==0x11; tcp SHALL be set when ipv4 && IHL==5 && proto==0x06.
REQ-019 A 16-bit byte counter SHALL add KEEP_WIDTH per accepted non-last beat and popcount(tkeep) on the last beat; tkeep is contiguous from lane 0.
REQ-020 m_desc_pk_len SHALL be ip_len+14 when ipv4, otherwise the byte count; the sum is 16-bit and wraps.
REQ-021 runt SHALL be set when tlast arrives before byte 37; a runt packet is classified non-IP.
REQ-022 Rule match: the lowest-index rule with en=1, is_tcp equal to tcp, port_src equal, and (udp||tcp) SHALL win.
REQ-023 On a match the descriptor SHALL take prio, flow_id, time and chain from the winning rule.
REQ-024 With no match the descriptor SHALL be prio=1, time=2, chain=0, flow_id=0xFF.
REQ-025 Round-robin: each rule has a toggle bit; when rr=1 the emitted chain item1 SHALL be rule item1 + toggle (4-bit wrap).
REQ-026 The toggle bit SHALL invert when that rule's descriptor is pushed into the FIFO.
REQ-027 In EMIT the descriptor SHALL be pushed into the FIFO; m_desc_valid is high from the next cycle when the FIFO was empty (tlast accept cycle T -> valid at T+2).
REQ-028 The FIFO SHALL pop on m_desc_valid && m_desc_ready; a simultaneous push and pop SHALL hold the count; m_desc_* SHALL be stable while valid && !ready.
REQ-029 s_axis_tready SHALL be low in IDLE while the FIFO holds FIFO_DEPTH entries minus one, plus one pending EMIT; otherwise it is high. A packet in progress is never stalled and a push never overflows.
REQ-030 A cfg write during a packet SHALL affect only packets whose EMIT follows the write edge.

Reset
REQ-031 rst_n low SHALL immediately set: FSM IDLE, counters 0, FIFO empty, m_desc_valid 0, all m_desc_* 0, toggles 0, stat_* 0, all rules en=0, s_axis_tready 1 once rst_n is released.
REQ-032 Reset asserted mid-packet SHALL discard the partial packet; the next accepted beat after release is treated as byte 0.

Configuration
REQ-033 Macro HDR_CLASSIFIER_STATS_EN defined: stat_pkt_count increments per EMIT, stat_udp_count per EMIT with udp, stat_match_count per EMIT with a rule hit; all three are 32-bit and wrap.
REQ-034 Macro HDR_CLASSIFIER_STATS_EN undefined: the counters are not built and stat_* are tied to 0.

Verification
REQ-035 DATA_WIDTH=64, rule0 = {en, udp, port 0, chain 0x0064, rr=1, prio 20}; two UDP packets, src port 0, ip_len 100 -> pk_len=114, prio 20, chain 0x0064 then 0x0074.
REQ-036 TCP packet, src port 1, no TCP rule -> prio 1, time 2, chain 0, flow 0xFF, flags 3'b010.
REQ-037 20-byte packet, tkeep 0x0F on the last beat at DATA_WIDTH=64 -> runt=1, pk_len=20.
REQ-038 m_desc_ready=0 and 8 packets at FIFO_DEPTH=8 -> s_axis_tready low at the 9th SOP; one pop -> tready high next cycle; no descriptor lost.
REQ-039 rst_n pulsed at beat 2 of a 4-beat packet, then a clean UDP packet -> exactly one descriptor, matching the clean packet; with STATS_EN, stat_pkt_count=1.
